// File: rtl/unpool_sequencer_if.sv
// Handshake and control bundle between the unpooling sequencer and its consumer.
// The sequencer drives the coordinate and control lines. The consumer drives start and out_ready.
interface unpool_sequencer_if #(
  parameter int H_BITW = 10,
  parameter int V_BITW = 9
);
  logic              start;
  logic              out_ready;
  logic              busy;
  logic              out_enable;
  logic [V_BITW-1:0] out_vcnt;
  logic [H_BITW-1:0] out_hcnt;
  logic [1:0]        quad;
  logic              fetch;
  logic              replay;
  logic [H_BITW-1:0] buf_addr;
  logic              done;

  modport master (
    input  start, out_ready,
    output busy, out_enable, out_vcnt, out_hcnt, quad, fetch, replay, buf_addr, done
  );

  modport slave (
    output start, out_ready,
    input  busy, out_enable, out_vcnt, out_hcnt, quad, fetch, replay, buf_addr, done
  );
endinterface

// File: rtl/unpool_sequencer.sv
// Raster sequencer for nearest-neighbour unpooling. It walks the output frame one pixel per transfer.
// It also flags when a coarse pixel is fetched from upstream or replayed from the line buffer.
module unpool_sequencer #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int LEVEL   = 0,
  parameter int H_BLANK = 2,
  parameter int H_BITW  = $clog2(WIDTH),
  parameter int V_BITW  = $clog2(HEIGHT)
) (
  input logic                clock,
  input logic                rst,
  unpool_sequencer_if.master bus
);

  localparam int B_BITW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(WIDTH - 1);
  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(HEIGHT - 1);
  localparam logic [B_BITW-1:0] B_LAST = B_BITW'(H_BLANK - 1);

  logic [1:0]        state_r, state_s;
  logic [H_BITW-1:0] hcnt_r, hcnt_s;
  logic [V_BITW-1:0] vcnt_r, vcnt_s;
  logic [B_BITW-1:0] blank_r, blank_s;
  logic              en_r, en_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              fetch_r, fetch_s;
  logic              replay_r, replay_s;

  // Next-state, counter and output decode; holding every value is the stall behaviour.
  always_comb begin
    state_s = state_r;
    hcnt_s  = hcnt_r;
    vcnt_s  = vcnt_r;
    blank_s = blank_r;
    en_s    = en_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_ACTIVE;
          hcnt_s  = '0;
          vcnt_s  = '0;
          en_s    = 1'b1;
          busy_s  = 1'b1;
        end else begin
          en_s    = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (en_r && bus.out_ready) begin
          if (hcnt_r == H_LAST) begin
            hcnt_s = '0;
            en_s   = 1'b0;
            if (vcnt_r == V_LAST) begin
              state_s = ST_DONE;
              vcnt_s  = '0;
              done_s  = 1'b1;
            end else begin
              state_s = ST_HBLANK;
              vcnt_s  = vcnt_r + V_BITW'(1);
              blank_s = B_LAST;
            end
          end else begin
            hcnt_s = hcnt_r + H_BITW'(1);
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        if (blank_r == '0) begin
          state_s = ST_ACTIVE;
          en_s    = 1'b1;
        end else begin
          blank_s = blank_r - B_BITW'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        en_s    = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        hcnt_s  = '0;
        vcnt_s  = '0;
        blank_s = '0;
        en_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
    // An access happens on the first output pixel of each coarse pixel. Line 0 of the block fetches, and later lines replay.
    fetch_s  = en_s && (hcnt_s[LEVEL:0] == '0) && (vcnt_s[LEVEL:0] == '0);
    replay_s = en_s && (hcnt_s[LEVEL:0] == '0) && (vcnt_s[LEVEL:0] != '0);
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      hcnt_r   <= '0;
      vcnt_r   <= '0;
      blank_r  <= '0;
      en_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      fetch_r  <= 1'b0;
      replay_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      hcnt_r   <= hcnt_s;
      vcnt_r   <= vcnt_s;
      blank_r  <= blank_s;
      en_r     <= en_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      fetch_r  <= fetch_s;
      replay_r <= replay_s;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.out_enable = en_r;
  assign bus.out_vcnt   = vcnt_r;
  assign bus.out_hcnt   = hcnt_r;
  assign bus.quad       = {vcnt_r[LEVEL], hcnt_r[LEVEL]};
  assign bus.fetch      = fetch_r;
  assign bus.replay     = replay_r;
  assign bus.buf_addr   = hcnt_r >> (LEVEL + 1);
  assign bus.done       = done_r;

endmodule

// File: tb/tb_unpool_sequencer.sv
// Self-checking bench for unpool_sequencer: a LEVEL=0 8x4 instance and a LEVEL=1 8x8 instance.
// Expected transfers are queued when a frame is started and popped as the DUT presents them.
module tb_unpool_sequencer;
  localparam int W   = 8;
  localparam int H0  = 4;
  localparam int H1  = 8;
  localparam int HB  = 2;
  localparam int HBW = $clog2(W);
  localparam int VB0 = $clog2(H0);
  localparam int VB1 = $clog2(H1);

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] h;
    logic [31:0] q;
    logic [31:0] f;
    logic [31:0] r;
    logic [31:0] b;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  unpool_sequencer_if #(.H_BITW(HBW), .V_BITW(VB0)) if0 ();
  unpool_sequencer_if #(.H_BITW(HBW), .V_BITW(VB1)) if1 ();

  unpool_sequencer #(.WIDTH(W), .HEIGHT(H0), .LEVEL(0), .H_BLANK(HB)) dut0 (
    .clock(clock), .rst(rst), .bus(if0)
  );
  unpool_sequencer #(.WIDTH(W), .HEIGHT(H1), .LEVEL(1), .H_BLANK(HB)) dut1 (
    .clock(clock), .rst(rst), .bus(if1)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(int v, int h, int lvl);
    exp_t e;
    int   m;
    m   = (1 << (lvl + 1)) - 1;
    e.v = 32'(v);
    e.h = 32'(h);
    e.q = 32'((((v >> lvl) & 1) << 1) | ((h >> lvl) & 1));
    e.f = 32'(((h & m) == 0) && ((v & m) == 0));
    e.r = 32'(((h & m) == 0) && ((v & m) != 0));
    e.b = 32'(h >> (lvl + 1));
    return e;
  endfunction

  function automatic exp_t obs0();
    exp_t o;
    o.v = 32'(if0.out_vcnt);
    o.h = 32'(if0.out_hcnt);
    o.q = 32'(if0.quad);
    o.f = 32'(if0.fetch);
    o.r = 32'(if0.replay);
    o.b = 32'(if0.buf_addr);
    return o;
  endfunction

  function automatic exp_t obs1();
    exp_t o;
    o.v = 32'(if1.out_vcnt);
    o.h = 32'(if1.out_hcnt);
    o.q = 32'(if1.quad);
    o.f = 32'(if1.fetch);
    o.r = 32'(if1.replay);
    o.b = 32'(if1.buf_addr);
    return o;
  endfunction

  function automatic logic [63:0] outs0();
    return 64'({if0.busy, if0.out_enable, if0.fetch, if0.replay, if0.done,
                if0.out_vcnt, if0.out_hcnt, if0.quad, if0.buf_addr});
  endfunction

  function automatic logic [63:0] outs1();
    return 64'({if1.busy, if1.out_enable, if1.fetch, if1.replay, if1.done,
                if1.out_vcnt, if1.out_hcnt, if1.quad, if1.buf_addr});
  endfunction

  task automatic test_reset();
    if0.start = 1'b0; if0.out_ready = 1'b0;
    if1.start = 1'b0; if1.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs0() !== 64'd0) begin
      $display("FAIL reset_dut0 got=%h exp=0", outs0()); errors++;
    end
    checks++;
    if (outs1() !== 64'd0) begin
      $display("FAIL reset_dut1 got=%h exp=0", outs1()); errors++;
    end
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (if0.busy !== 1'b0 || if0.out_enable !== 1'b0) begin
      $display("FAIL idle_after_reset busy=%b en=%b exp 0 0", if0.busy, if0.out_enable); errors++;
    end
  endtask

  task automatic test_frame_l0();
    int   xfers = 0, busy_cyc = 0, gap_run = 0, gaps = 0, dones = 0;
    bit   last_final = 1'b0, finished = 1'b0;
    exp_t e, o;
    q0.delete();
    for (int v = 0; v < H0; v++)
      for (int h = 0; h < W; h++) q0.push_back(model(v, h, 0));
    if0.out_ready = 1'b1;
    if0.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
    checks++;
    if (if0.out_enable !== 1'b1 || if0.busy !== 1'b1) begin
      $display("FAIL start_latency en=%b busy=%b exp 1 1", if0.out_enable, if0.busy); errors++;
    end
    for (int c = 0; c < 200 && !finished; c++) begin
      o = obs0();
      if (if0.busy === 1'b1) busy_cyc++;
      if (dones > 0) begin
        finished = 1'b1;
        checks++;
        if (outs0() !== 64'd0) begin
          $display("FAIL idle_after_done got=%h exp=0", outs0()); errors++;
        end
      end else begin
        if (if0.done === 1'b1) begin
          dones++;
          checks++;
          if (!last_final) begin
            $display("FAIL done_timing got done=1 without transfer (3,7) on the previous cycle"); errors++;
          end
        end
        last_final = 1'b0;
        checks++;
        if ((if0.fetch === 1'b1 && if0.replay === 1'b1) ||
            (if0.out_enable !== 1'b1 && (if0.fetch !== 1'b0 || if0.replay !== 1'b0))) begin
          $display("FAIL fetch_replay_excl got en=%b f=%b r=%b", if0.out_enable, if0.fetch, if0.replay); errors++;
        end
        if (if0.out_enable === 1'b1 && if0.out_ready === 1'b1) begin
          xfers++;
          checks++;
          if (q0.size() == 0) begin
            $display("FAIL sb0_extra got transfer (%0d,%0d) exp none", o.v, o.h); errors++;
          end else begin
            e = q0.pop_front();
            if (o !== e) begin
              $display("FAIL sb0 got v=%0d h=%0d q=%0d f=%0d r=%0d b=%0d exp v=%0d h=%0d q=%0d f=%0d r=%0d b=%0d",
                       o.v, o.h, o.q, o.f, o.r, o.b, e.v, e.h, e.q, e.f, e.r, e.b);
              errors++;
            end
          end
          if (o.v == 32'(H0 - 1) && o.h == 32'(W - 1)) last_final = 1'b1;
          if (gap_run > 0) begin
            checks++;
            if (gap_run != HB) begin
              $display("FAIL hblank_len got=%0d exp=%0d", gap_run, HB); errors++;
            end
            gaps++;
            gap_run = 0;
          end
        end else if (if0.busy === 1'b1 && if0.done !== 1'b1) begin
          gap_run++;
        end
      end
      if (!finished) @(negedge clock);
    end
    checks++;
    if (!finished) begin $display("FAIL frame0_timeout got no end of frame exp done"); errors++; end
    checks++;
    if (xfers != 32) begin $display("FAIL frame0_xfers got=%0d exp=32", xfers); errors++; end
    checks++;
    if (busy_cyc != 39) begin $display("FAIL frame0_busy got=%0d exp=39", busy_cyc); errors++; end
    checks++;
    if (gaps != 3) begin $display("FAIL frame0_gaps got=%0d exp=3", gaps); errors++; end
    checks++;
    if (dones != 1) begin $display("FAIL frame0_done got=%0d exp=1", dones); errors++; end
    checks++;
    if (q0.size() != 0) begin $display("FAIL frame0_left got=%0d exp=0", q0.size()); errors++; end
  endtask

  task automatic test_stall();
    int          xfers = 0, dones = 0, stall_left = 0;
    bit          stalled = 1'b0, expect_next = 1'b0, finished = 1'b0;
    logic [63:0] snap = 64'd0;
    exp_t        e, o;
    q0.delete();
    for (int v = 0; v < H0; v++)
      for (int h = 0; h < W; h++) q0.push_back(model(v, h, 0));
    if0.out_ready = 1'b1;
    if0.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      o = obs0();
      if (dones > 0) begin
        finished = 1'b1;
      end else begin
        if (if0.done === 1'b1) dones++;
        if (!stalled && if0.out_enable === 1'b1 && o.v == 32'd1 && o.h == 32'd3) begin
          stalled = 1'b1;
          stall_left = 5;
          snap = outs0();
          if0.out_ready = 1'b0;
          checks++;
          if (if0.quad !== 2'b11) begin $display("FAIL stall_quad got=%b exp=11", if0.quad); errors++; end
        end else if (stall_left > 0) begin
          checks++;
          if (outs0() !== snap) begin
            $display("FAIL stall_frozen got=%h exp=%h", outs0(), snap); errors++;
          end
          stall_left--;
          if (stall_left == 0) begin
            if0.out_ready = 1'b1;
            expect_next = 1'b1;
          end
        end else if (expect_next) begin
          expect_next = 1'b0;
          checks++;
          if (o.v != 32'd1 || o.h != 32'd4 || if0.out_enable !== 1'b1) begin
            $display("FAIL stall_resume got (%0d,%0d) en=%b exp (1,4) en=1", o.v, o.h, if0.out_enable); errors++;
          end
        end
        if (if0.out_enable === 1'b1 && if0.out_ready === 1'b1) begin
          xfers++;
          checks++;
          if (q0.size() == 0) begin
            $display("FAIL sb0s_extra got transfer (%0d,%0d) exp none", o.v, o.h); errors++;
          end else begin
            e = q0.pop_front();
            if (o !== e) begin
              $display("FAIL sb0s got v=%0d h=%0d exp v=%0d h=%0d", o.v, o.h, e.v, e.h); errors++;
            end
          end
        end
      end
      if (!finished) @(negedge clock);
    end
    checks++;
    if (!finished || !stalled) begin
      $display("FAIL stall_timeout got finished=%b stalled=%b exp 1 1", finished, stalled); errors++;
    end
    checks++;
    if (xfers != 32) begin $display("FAIL stall_xfers got=%0d exp=32", xfers); errors++; end
  endtask

  task automatic test_level1();
    int   xfers = 0, nf = 0, nr = 0, dones = 0;
    bit   finished = 1'b0;
    exp_t e, o;
    q1.delete();
    for (int v = 0; v < H1; v++)
      for (int h = 0; h < W; h++) q1.push_back(model(v, h, 1));
    if1.out_ready = 1'b1;
    if1.start = 1'b1;
    @(negedge clock);
    if1.start = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      o = obs1();
      if (dones > 0) begin
        finished = 1'b1;
      end else begin
        if (if1.done === 1'b1) dones++;
        if (if1.out_enable === 1'b1 && if1.out_ready === 1'b1) begin
          xfers++;
          if (if1.fetch === 1'b1) nf++;
          if (if1.replay === 1'b1) nr++;
          checks++;
          if (q1.size() == 0) begin
            $display("FAIL sb1_extra got transfer (%0d,%0d) exp none", o.v, o.h); errors++;
          end else begin
            e = q1.pop_front();
            if (o !== e) begin
              $display("FAIL sb1 got v=%0d h=%0d q=%0d f=%0d r=%0d b=%0d exp v=%0d h=%0d q=%0d f=%0d r=%0d b=%0d",
                       o.v, o.h, o.q, o.f, o.r, o.b, e.v, e.h, e.q, e.f, e.r, e.b);
              errors++;
            end
          end
        end
      end
      if (!finished) @(negedge clock);
    end
    checks++;
    if (!finished) begin $display("FAIL level1_timeout got no end of frame exp done"); errors++; end
    checks++;
    if (xfers != 64) begin $display("FAIL level1_xfers got=%0d exp=64", xfers); errors++; end
    checks++;
    if (nf != 4 || nr != 12) begin
      $display("FAIL level1_access got fetch=%0d replay=%0d exp 4 12", nf, nr); errors++;
    end
  endtask

  task automatic test_midframe_reset();
    bit   hit = 1'b0;
    exp_t o;
    if0.out_ready = 1'b1;
    if0.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      o = obs0();
      if (if0.start === 1'b1) begin
        if0.start = 1'b0;
        checks++;
        if (o.v != 32'd2 || o.h != 32'd2 || if0.busy !== 1'b1) begin
          $display("FAIL start_ignored got (%0d,%0d) busy=%b exp (2,2) busy=1", o.v, o.h, if0.busy); errors++;
        end
      end else if (if0.out_enable === 1'b1 && o.v == 32'd2 && o.h == 32'd1) begin
        if0.start = 1'b1;
      end else if (if0.out_enable === 1'b1 && o.v == 32'd2 && o.h == 32'd5) begin
        hit = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (outs0() !== 64'd0) begin
          $display("FAIL async_reset got=%h exp=0", outs0()); errors++;
        end
      end else begin
        hit = 1'b0;
      end
      if (!hit) @(negedge clock);
    end
    checks++;
    if (!hit) begin $display("FAIL midframe_timeout got no (2,5) exp (2,5)"); errors++; end
    @(negedge clock);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (if0.busy !== 1'b0 || if0.out_enable !== 1'b0) begin
        $display("FAIL no_resume got busy=%b en=%b exp 0 0", if0.busy, if0.out_enable); errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_l0();
    test_stall();
    test_level1();
    test_midframe_reset();
    test_frame_l0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unpool_sequencer.md
UNPOOL_SEQUENCER -- requirements
Module: unpool_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning output frame width in pixels, a multiple of 2^(LEVEL+1).
REQ-002 SHALL have parameter HEIGHT, default 480, meaning output frame height in lines, a multiple of 2^(LEVEL+1).
REQ-003 SHALL have parameter LEVEL, default 0, meaning the unpooling level; one coarse pixel covers a 2^(LEVEL+1) square of output pixels.
REQ-004 SHALL have parameter H_BLANK, default 2, meaning idle cycles inserted after each line, at least 1.
REQ-005 SHALL derive H_BITW = ceil(log2(WIDTH)) and V_BITW = ceil(log2(HEIGHT)).
REQ-006 clock  input  1  single clock; all logic is rising-edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 start  input  1  frame start request, one-cycle pulse.
REQ-009 out_ready  input  1  downstream can accept the current output.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 out_enable  output  1  current coordinate and controls are valid.
REQ-012 out_vcnt  output  V_BITW  output line index.
REQ-013 out_hcnt  output  H_BITW  output pixel index.
REQ-014 quad  output  2  quadrant {out_vcnt[LEVEL], out_hcnt[LEVEL]}: 00=UL, 01=UR, 10=LL, 11=LR.
REQ-015 fetch  output  1  a new coarse pixel is taken from upstream.
REQ-016 replay  output  1  a coarse pixel is re-read from the line buffer.
REQ-017 buf_addr  output  H_BITW  line-buffer address, equal to out_hcnt >> (LEVEL+1).
REQ-018 done  output  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement states IDLE, ACTIVE, HBLANK and DONE, and SHALL register all outputs.
REQ-020 In IDLE, start=1 SHALL move the block to ACTIVE on the next edge, with out_vcnt=0, out_hcnt=0, out_enable=1 and busy=1. Latency from start to the first valid output is 1 cycle.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 In ACTIVE, a transfer SHALL occur on each edge where out_enable=1 and out_ready=1; only a transfer advances out_hcnt.
REQ-023 While out_enable=1 and out_ready=0, every output SHALL hold its value.
REQ-024 A transfer at out_hcnt=WIDTH-1 on a line other than HEIGHT-1 SHALL:
  - reset out_hcnt to 0;
  - increment out_vcnt;
  - enter HBLANK with out_enable=0 for exactly H_BLANK cycles, regardless of out_ready;
  - then return to ACTIVE.
REQ-025 A transfer at out_hcnt=WIDTH-1 and out_vcnt=HEIGHT-1 SHALL enter DONE. DONE lasts one cycle with done=1 and out_enable=0, then returns to IDLE with busy=0 and both counters at 0.
REQ-026 fetch SHALL be 1 exactly when out_enable=1, out_hcnt[LEVEL:0]=0 and out_vcnt[LEVEL:0]=0.
REQ-027 replay SHALL be 1 exactly when out_enable=1, out_hcnt[LEVEL:0]=0 and out_vcnt[LEVEL:0]!=0.
REQ-028 fetch and replay SHALL never be 1 together. A stalled fetch or replay stays asserted but counts as a single access.
REQ-029 quad and buf_addr SHALL be combinational functions of the registered counters, and therefore valid whenever out_enable=1.
REQ-030 Counters SHALL never exceed WIDTH-1 or HEIGHT-1; no wrap-around SHALL occur inside a frame.
REQ-031 If start and out_ready both toggle in the IDLE-to-ACTIVE cycle, out_ready SHALL have no effect until out_enable=1.

Reset
REQ-032 rst=1 SHALL, asynchronously and at any point including mid-frame:
  - force IDLE;
  - drive busy, out_enable, fetch, replay and done to 0;
  - clear out_vcnt, out_hcnt and buf_addr to 0 (so quad=00).
REQ-033 After rst falls, the block SHALL wait for a fresh start pulse; no partial frame resumes.

Verification
REQ-034 WIDTH=8, HEIGHT=4, LEVEL=0, H_BLANK=2, out_ready=1, start pulse -> expected:
  - 32 transfers in raster order, each line followed by a 2-cycle gap;
  - done high 1 cycle after transfer (3,7);
  - busy for 32+3*2+1 cycles.
REQ-035 Same configuration -> expected:
  - fetch at (0,0),(0,2),(0,4),(0,6),(2,0)...;
  - replay at (1,0),(1,2),(1,4),(1,6),(3,*) even columns;
  - quad sequence on line 1 = 10,11,10,11...
REQ-036 LEVEL=1, WIDTH=8, HEIGHT=8 -> expected:
  - fetch only on lines 0 and 4 at columns 0 and 4;
  - replay on lines 1-3 and 5-7 at columns 0 and 4;
  - buf_addr = 0,0,0,0,1,1,1,1 across a line.
REQ-037 out_ready held low for 5 cycles at (1,3) -> expected: outputs frozen at (1,3), quad=11, then (1,4) on the first cycle after out_ready rises; total transfer count unchanged at 32.
REQ-038 rst asserted at (2,5) -> expected:
  - all outputs 0 immediately, without waiting for a clock edge;
  - start during busy ignored;
  - a new start after reset gives a full 32-transfer frame from (0,0).
